// File: rtl/button_debouncer.sv
// Pushbutton debouncer: two-flop synchronizer followed by a four-state FSM that
// accepts a new level only after STABLE_TICKS consecutive tick samples agree.
module button_debouncer #(
  parameter int unsigned STABLE_TICKS = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic tick,
  input  logic btn_in,
  output logic btn_level,
  output logic btn_press,
  output logic btn_release
);

  localparam int unsigned CNT_W = $clog2(STABLE_TICKS + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(STABLE_TICKS - 1);

  typedef enum logic [1:0] {
    LOW_STABLE,
    WAIT_HIGH,
    HIGH_STABLE,
    WAIT_LOW
  } state_e;

  logic             sync1_q, sync2_q;
  logic             btn_s;
  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             level_q, level_d;
  logic             press_q, press_d;
  logic             release_q, release_d;

  assign btn_s = sync2_q;

  // NOTE: all clocked state uses non-blocking assignments so every flop samples
  // pre-edge values; blocking here would collapse the synchronizer into one flop.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q   <= 1'b0;
      sync2_q   <= 1'b0;
      state_q   <= LOW_STABLE;
      cnt_q     <= '0;
      level_q   <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
    end else begin
      sync1_q   <= btn_in;
      sync2_q   <= sync1_q;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
    end
  end

  // NOTE: defaults assigned up front so no path through the case infers a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      LOW_STABLE: begin
        if (btn_s) begin
          state_d = WAIT_HIGH;
          cnt_d   = '0;
        end
      end
      WAIT_HIGH: begin
        // A bounce back to the old level wins over a coincident tick.
        if (!btn_s) begin
          state_d = LOW_STABLE;
          cnt_d   = '0;
        end else if (tick) begin
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == LAST_CNT) state_d = HIGH_STABLE;
        end
      end
      HIGH_STABLE: begin
        if (!btn_s) begin
          state_d = WAIT_LOW;
          cnt_d   = '0;
        end
      end
      WAIT_LOW: begin
        if (btn_s) begin
          state_d = HIGH_STABLE;
          cnt_d   = '0;
        end else if (tick) begin
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == LAST_CNT) state_d = LOW_STABLE;
        end
      end
      default: begin
        state_d = LOW_STABLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Outputs are derived from the upcoming state so they land on the same edge.
  always_comb begin
    level_d   = (state_d == HIGH_STABLE) || (state_d == WAIT_LOW);
    press_d   = (state_q == WAIT_HIGH) && (state_d == HIGH_STABLE);
    release_d = (state_q == WAIT_LOW) && (state_d == LOW_STABLE);
  end

  assign btn_level   = level_q;
  assign btn_press   = press_q;
  assign btn_release = release_q;

endmodule

// File: tb/tb_button_debouncer.sv
// Bench for button_debouncer: two instances (STABLE_TICKS 4 and 1) driven in
// parallel and compared each cycle against a run-length reference model.
module tb_button_debouncer;

  logic clk = 1'b0;
  logic reset, tick, btn_in;
  logic lvl_o [2];
  logic prs_o [2];
  logic rel_o [2];

  always #5 clk = ~clk;

  button_debouncer #(.STABLE_TICKS(4)) dut4 (
    .clk(clk), .reset(reset), .tick(tick), .btn_in(btn_in),
    .btn_level(lvl_o[0]), .btn_press(prs_o[0]), .btn_release(rel_o[0])
  );

  button_debouncer #(.STABLE_TICKS(1)) dut1 (
    .clk(clk), .reset(reset), .tick(tick), .btn_in(btn_in),
    .btn_level(lvl_o[1]), .btn_press(prs_o[1]), .btn_release(rel_o[1])
  );

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  int npress [2] = '{0, 0};

  // Reference model: a two-sample delay line, then per instance the accepted
  // level plus "a run of the opposite level is in progress, n ticks seen".
  localparam int ST [2] = '{4, 1};
  logic m_s1 = 1'b0, m_s2 = 1'b0;
  logic m_lvl [2] = '{1'b0, 1'b0};
  logic m_run [2] = '{1'b0, 1'b0};
  int   m_n   [2] = '{0, 0};
  logic m_prs [2] = '{1'b0, 1'b0};
  logic m_rel [2] = '{1'b0, 1'b0};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s at cycle %0d: observed %0d expected %0d", tag, cyc, obs, exp);
    end
  endtask

  task automatic model_step(input logic b, input logic t, input logic r);
    for (int i = 0; i < 2; i++) begin
      m_prs[i] = 1'b0;
      m_rel[i] = 1'b0;
      if (r) begin
        m_lvl[i] = 1'b0;
        m_run[i] = 1'b0;
        m_n[i]   = 0;
      end else if (!m_run[i]) begin
        if (m_s2 != m_lvl[i]) begin
          m_run[i] = 1'b1;
          m_n[i]   = 0;
        end
      end else if (m_s2 == m_lvl[i]) begin
        m_run[i] = 1'b0;
      end else if (t) begin
        m_n[i]++;
        if (m_n[i] == ST[i]) begin
          m_lvl[i] = m_s2;
          m_run[i] = 1'b0;
          m_prs[i] = m_s2;
          m_rel[i] = !m_s2;
        end
      end
    end
    m_s2 = r ? 1'b0 : m_s1;
    m_s1 = r ? 1'b0 : b;
  endtask

  task automatic cycle(input logic b, input logic t, input logic r);
    @(negedge clk);
    btn_in = b;
    tick   = t;
    reset  = r;
    @(posedge clk);
    model_step(b, t, r);
    #1;
    cyc++;
    for (int i = 0; i < 2; i++) begin
      check($sformatf("level[%0d]", ST[i]), 32'(lvl_o[i]), 32'(m_lvl[i]));
      check($sformatf("press[%0d]", ST[i]), 32'(prs_o[i]), 32'(m_prs[i]));
      check($sformatf("release[%0d]", ST[i]), 32'(rel_o[i]), 32'(m_rel[i]));
      if (prs_o[i] === 1'b1) npress[i]++;
    end
  endtask

  // mode 0: tick every 5th clk, 1: tick held high, 2: no ticks
  task automatic run(input logic b, input int n, input int mode);
    for (int k = 0; k < n; k++)
      cycle(b, (mode == 1) || (mode == 0 && (cyc % 5) == 4), 1'b0);
  endtask

  initial begin
    int p0;
    int hit;
    btn_in = 1'b0;
    tick   = 1'b0;
    reset  = 1'b1;

    // Reset state, with tick and btn_in active to show reset overrides them.
    cycle(1'b0, 1'b0, 1'b1);
    cycle(1'b1, 1'b1, 1'b1);
    cycle(1'b1, 1'b1, 1'b1);
    check("reset_level", 32'(lvl_o[0]), 0);
    check("reset_press", 32'(prs_o[0]), 0);

    // Clean press and release with periodic ticks.
    run(1'b0, 5, 0);
    p0 = npress[0];
    run(1'b1, 40, 0);
    check("clean_press_count", npress[0] - p0, 1);
    check("clean_level", 32'(lvl_o[0]), 1);
    run(1'b0, 40, 0);
    check("release_level", 32'(lvl_o[0]), 0);
    check("release_no_press", npress[0] - p0, 1);

    // Bounce 1,0,1,0 then hold: exactly one press on the stable instance.
    p0 = npress[0];
    run(1'b1, 8, 0);
    run(1'b0, 4, 0);
    run(1'b1, 8, 0);
    run(1'b0, 4, 0);
    run(1'b1, 40, 0);
    check("bounce_press_count", npress[0] - p0, 1);
    run(1'b0, 12, 1);

    // btn_s falls on the same cycle as the tick that would reach the count.
    p0 = npress[0];
    run(1'b1, 3, 2);
    run(1'b1, 3, 1);
    run(1'b0, 2, 2);
    run(1'b0, 1, 1);
    run(1'b0, 8, 1);
    check("simul_no_press", npress[0] - p0, 0);
    check("simul_level", 32'(lvl_o[0]), 0);

    // Reset at count 2 in WAIT_HIGH, btn_in held high throughout.
    p0 = npress[0];
    run(1'b1, 3, 2);
    run(1'b1, 2, 1);
    cycle(1'b1, 1'b1, 1'b1);
    check("rst_mid_level", 32'(lvl_o[0]), 0);
    check("rst_mid_press", 32'(prs_o[0]), 0);
    run(1'b1, 3, 2);
    run(1'b1, 3, 1);
    check("rst_mid_not_yet", 32'(lvl_o[0]), 0);
    run(1'b1, 1, 1);
    check("rst_mid_press_after", 32'(prs_o[0]), 1);
    check("rst_mid_press_count", npress[0] - p0, 1);
    run(1'b0, 12, 1);

    // Tick held high: STABLE_TICKS=1 accepts the cycle after entry (cycle 4),
    // STABLE_TICKS=4 on cycle 7; each press lasts one clock.
    hit = 0;
    for (int k = 1; k <= 10; k++) begin
      cycle(1'b1, 1'b1, 1'b0);
      if (prs_o[1] === 1'b1) begin
        check("st1_press_cycle", k, 4);
        hit++;
      end
      if (prs_o[0] === 1'b1) begin
        check("st4_press_cycle", k, 7);
        hit++;
      end
    end
    check("held_tick_press_pulses", hit, 2);
    run(1'b0, 12, 1);

    // Randomized bursts with occasional reset.
    begin
      logic b = 1'b0;
      for (int k = 0; k < 1500; k++) begin
        if ($urandom_range(11) == 0) b = ~b;
        cycle(b, $urandom_range(2) == 0, $urandom_range(299) == 0);
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
